bdd_node_table_ctrl: RTL and testbench
======================================

Name: bdd_node_table_ctrl

Overview:
Controller that shares the dual-port node-table SRAM (write port A, registered read port B, 1-cycle read latency) between NUM_REQ BDD engine requesters.
- Writes are node allocations. The controller owns the free pointer, hands out the next address and raises full.
- Reads are round-robin arbitrated. Each response is tagged with the requester id.
- Sits between the BDD apply/reduce engines and the node-table SRAM instance.

Parameters:
ADDR_WIDTH, 8, SRAM address width
DATA_WIDTH, 34, node word width
DEPTH, 8, number of node-table entries (DEPTH <= 2**ADDR_WIDTH)
NUM_REQ, 2, number of requesters (>= 2)
ID_WIDTH, $clog2(NUM_REQ), width of the response tag

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  reset, synchronous active-high
clear  input  1  synchronous table flush: count returns to 0
wr_req  input  NUM_REQ  per-requester allocate request, held until granted
wr_data  input  NUM_REQ*DATA_WIDTH  per-requester node word, requester i at slice i
wr_gnt  output  NUM_REQ  one-hot allocate grant, combinational
wr_addr  output  ADDR_WIDTH  address allocated to the granted writer, valid while any wr_gnt bit is set
rd_req  input  NUM_REQ  per-requester read request, held until granted
rd_addr  input  NUM_REQ*ADDR_WIDTH  per-requester read address
rd_gnt  output  NUM_REQ  one-hot read grant, combinational
rd_valid  output  1  read response valid, registered
rd_id  output  ID_WIDTH  requester index of the response
rd_data  output  DATA_WIDTH  response node word
rd_err  output  1  response addressed an unallocated entry
count  output  ADDR_WIDTH+1  number of allocated entries
full  output  1  count == DEPTH
sram_data_a  output  DATA_WIDTH  to SRAM data_a
sram_addr_a  output  ADDR_WIDTH  to SRAM addr_a
sram_we_a  output  1  to SRAM we_a
sram_addr_b  output  ADDR_WIDTH  to SRAM addr_b
sram_q_b  input  DATA_WIDTH  from SRAM q_b

Behaviour:
- Reset (rst=1 at posedge) sets:
  - count = 0, full = 0;
  - rd_valid = 0, rd_id = 0, rd_data = 0, rd_err = 0;
  - both round-robin pointers = requester 0.
  - While rst=1, all grants and sram_we_a are 0.
- Reset mid-operation: an in-flight read response is dropped (rd_valid is 0 on the next cycle). A write granted in the rst cycle does not occur.
- Write arbitration:
  - Round-robin among wr_req bits, searching from the write pointer.
  - No grant while full=1 or clear=1.
  - In the grant cycle:
    - sram_we_a = 1, sram_addr_a = count[ADDR_WIDTH-1:0], sram_data_a = the winner's slice;
    - wr_addr = count;
    - at the posedge, count increments and the write pointer moves to winner+1 (mod NUM_REQ).
- The write pointer advances only when a grant is issued.
- full is combinational from count. After the DEPTH-th allocation, full=1 and further wr_req bits wait without a grant.
- clear at posedge sets count to 0. clear has priority over a simultaneous increment: no write is granted in that cycle. SRAM contents are not erased.
- Read arbitration:
  - Independent round-robin among rd_req bits with its own pointer.
  - A read grant is issued whenever any request is present, except during rst.
  - In the grant cycle, sram_addr_b = the winner's address.
  - The next cycle carries the response: rd_valid = 1, rd_id = winner, rd_data = sram_q_b.
  - One read per cycle, fully pipelined: back-to-back grants give back-to-back rd_valid.
- Read of an unallocated entry: when the winner's address >= count (sampled in the grant cycle), the response has rd_err = 1 and rd_data = 0.
  - This covers a read of the address being allocated in the same cycle. No write-to-read forwarding is provided.
- A read and a write in the same cycle are independent and both are granted.
- When idle, sram outputs are driven 0 and rd_valid is 0.

Decomposition:
- Package bdd_mem_pkg holds:
  - the ADDR_WIDTH/DATA_WIDTH/DEPTH defaults;
  - node field constants: var index width, low/high child pointer widths inside the 34-bit word.
- One sub-module, rr_arbiter (parameter N), instantiated twice (write and read):
  - inputs req, advance;
  - outputs one-hot gnt, binary gnt_idx;
  - holds its pointer, with synchronous active-high rst.

Test Plan:
1. Reset, then wr_req=01 with data 0x155 -> wr_gnt=01, wr_addr=0, sram_we_a=1, count=1 next cycle.
2. wr_req=11 held for 4 cycles -> grants alternate 01, 10, 01, 10 at addresses 0..3; count=4.
3. Fill to DEPTH=8 -> full=1. A further wr_req=01 gets no grant and sram_we_a=0. Then clear -> count=0, full=0, and the request is granted at addr 0 the next cycle.
4. After writing 0xA5 at addr 2, rd_req=11 with both addresses = 2 -> back-to-back responses with rd_id 0 then 1, both rd_data=0xA5, rd_err=0.
5. Read addr 5 with count=3 -> rd_valid=1, rd_err=1, rd_data=0.
6. rst asserted in the cycle after a read grant -> rd_valid=0, count=0, next grant goes to requester 0.

Source files
------------

// File: rtl/bdd_mem_pkg.sv
// -----------------------------------------------------------------------------
// bdd_mem_pkg
// Shared constants for the BDD node-table memory subsystem.
//   - default geometry of the node-table SRAM (address width, word width, depth)
//   - layout of a 34-bit node word: {var index, low child, high child}
//   - a packed struct view of a node word and a helper that builds one
// No ports: this is a package imported by the node-table controller.
// -----------------------------------------------------------------------------
package bdd_mem_pkg;

  // Default geometry of the node-table SRAM
  localparam int BDD_ADDR_WIDTH = 8;
  localparam int BDD_DATA_WIDTH = 34;
  localparam int BDD_DEPTH      = 8;

  // Node word fields, most significant first: variable index, low child, high child
  localparam int NODE_VAR_WIDTH = 10;
  localparam int NODE_LO_WIDTH  = 12;
  localparam int NODE_HI_WIDTH  = 12;
  localparam int NODE_HI_LSB    = 0;
  localparam int NODE_LO_LSB    = NODE_HI_LSB + NODE_HI_WIDTH;
  localparam int NODE_VAR_LSB   = NODE_LO_LSB + NODE_LO_WIDTH;

  typedef struct packed {
    logic [NODE_VAR_WIDTH-1:0] varIdx;
    logic [NODE_LO_WIDTH-1:0]  loChild;
    logic [NODE_HI_WIDTH-1:0]  hiChild;
  } node_t;

  // Builds a flat node word from its three fields
  function automatic logic [BDD_DATA_WIDTH-1:0] packNode(
    input logic [NODE_VAR_WIDTH-1:0] varIdx,
    input logic [NODE_LO_WIDTH-1:0]  loChild,
    input logic [NODE_HI_WIDTH-1:0]  hiChild
  );
    node_t n;
    n.varIdx  = varIdx;
    n.loChild = loChild;
    n.hiChild = hiChild;
    return n;
  endfunction

endpackage

// File: rtl/bdd_node_table_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The requester at the pointer has highest priority, then
// pointer+1, and so on with wrap-around. When 'advance' is high and a grant is
// issued, the pointer moves to the winner + 1 so the winner becomes lowest
// priority next time.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset, pointer returns to requester 0
//   req      - request vector
//   advance  - move the pointer past the current winner at the next edge
//   gnt      - one-hot grant (all zero when no request)
//   gnt_idx  - binary index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [2*N-1:0]   reqRot;
  int               offset;
  int               winner;
  int               nextPtr;

  // Rotate the requests so the pointer position lands at bit 0, pick the lowest
  // set bit, then rotate the offset back to an absolute requester index.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    offset  = 0;
    winner  = 0;
    nextPtr = 0;
    ptr_d   = ptr_q;
    reqRot  = {req, req} >> ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      if (reqRot[k]) begin
        offset = k;
      end
    end
    if (|req) begin
      winner = int'(ptr_q) + offset;
      if (winner >= N) begin
        winner = winner - N;
      end
      gnt_idx = IDX_W'(winner);
      gnt     = {{(N-1){1'b0}}, 1'b1} << gnt_idx;
      if (advance) begin
        nextPtr = winner + 1;
        if (nextPtr >= N) begin
          nextPtr = 0;
        end
        ptr_d = IDX_W'(nextPtr);
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bdd_node_table_ctrl.sv
// -----------------------------------------------------------------------------
// bdd_node_table_ctrl
// Shares the dual-port node-table SRAM (write port A, registered read port B
// with one cycle of latency) between NUM_REQ BDD engine requesters.
// Writes are node allocations: the controller owns the free pointer (count),
// hands the next address to a round-robin write winner and raises full.
// Reads are round-robin arbitrated independently and their responses are
// tagged with the requester index one cycle after the grant.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   clear                  - flush the table: count returns to 0
//   wr_req / wr_data       - per-requester allocate request and node word
//   wr_gnt / wr_addr       - one-hot allocate grant and the address handed out
//   rd_req / rd_addr       - per-requester read request and address
//   rd_gnt                 - one-hot read grant
//   rd_valid/rd_id/rd_data/rd_err - registered read response
//   count / full           - allocated entries, count == DEPTH
//   sram_*                 - connections to the node-table SRAM instance
// -----------------------------------------------------------------------------
module bdd_node_table_ctrl
  import bdd_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = BDD_ADDR_WIDTH,
  parameter int DATA_WIDTH = BDD_DATA_WIDTH,
  parameter int DEPTH      = BDD_DEPTH,
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_gnt,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic                          rd_valid,
  output logic [ID_WIDTH-1:0]           rd_id,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_err,
  output logic [ADDR_WIDTH:0]           count,
  output logic                          full,
  output logic [DATA_WIDTH-1:0]         sram_data_a,
  output logic [ADDR_WIDTH-1:0]         sram_addr_a,
  output logic                          sram_we_a,
  output logic [ADDR_WIDTH-1:0]         sram_addr_b,
  input  logic [DATA_WIDTH-1:0]         sram_q_b
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  rdValid_q, rdValid_d;
  logic [ID_WIDTH-1:0]   rdId_q, rdId_d;
  logic                  rdErr_q, rdErr_d;

  logic [NUM_REQ-1:0]    wrReqEff, rdReqEff;
  logic [ID_WIDTH-1:0]   wrIdx, rdIdx;
  logic                  wrAny, rdAny;
  logic [DATA_WIDTH-1:0] wrWinData;
  logic [ADDR_WIDTH-1:0] rdWinAddr;

  // Requests are masked before arbitration so that a blocked write or a
  // request during reset never moves a round-robin pointer.
  always_comb begin
    full     = (count_q == DEPTH_C);
    wrReqEff = (rst || full || clear) ? '0 : wr_req;
    rdReqEff = rst ? '0 : rd_req;
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_WIDTH)
  ) u_wrArb (
    .clk     (clk),
    .rst     (rst),
    .req     (wrReqEff),
    .advance (wrAny),
    .gnt     (wr_gnt),
    .gnt_idx (wrIdx)
  );

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_WIDTH)
  ) u_rdArb (
    .clk     (clk),
    .rst     (rst),
    .req     (rdReqEff),
    .advance (rdAny),
    .gnt     (rd_gnt),
    .gnt_idx (rdIdx)
  );

  // Select the winning writer's node word and winning reader's address from
  // the packed per-requester buses using the one-hot grants.
  always_comb begin
    wrWinData = '0;
    rdWinAddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        wrWinData = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (rd_gnt[i]) begin
        rdWinAddr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // SRAM port drive: everything stays at zero unless a grant is issued, and a
  // write always lands at the current free pointer.
  always_comb begin
    wrAny       = |wr_gnt;
    rdAny       = |rd_gnt;
    sram_we_a   = wrAny;
    sram_addr_a = '0;
    sram_data_a = '0;
    wr_addr     = '0;
    if (wrAny) begin
      sram_addr_a = count_q[ADDR_WIDTH-1:0];
      sram_data_a = wrWinData;
      wr_addr     = count_q[ADDR_WIDTH-1:0];
    end
    sram_addr_b = rdAny ? rdWinAddr : '0;
  end

  // Next-state for the free pointer and the read response pipeline stage.
  // The error flag compares against the count seen in the grant cycle, so a
  // read of the entry being allocated in that same cycle is reported as an
  // error rather than forwarded.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wrAny) begin
      count_d = count_q + ONE_C;
    end
    rdValid_d = rdAny;
    rdId_d    = rdAny ? rdIdx : '0;
    rdErr_d   = rdAny && ({1'b0, rdWinAddr} >= count_q);
  end

  // State registers; reset drops any response that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      rdValid_q <= 1'b0;
      rdId_q    <= '0;
      rdErr_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      rdValid_q <= rdValid_d;
      rdId_q    <= rdId_d;
      rdErr_q   <= rdErr_d;
    end
  end

  // The SRAM read data arrives in the response cycle; it is suppressed for
  // idle cycles and for reads of unallocated entries.
  always_comb begin
    count    = count_q;
    rd_valid = rdValid_q;
    rd_id    = rdId_q;
    rd_err   = rdErr_q;
    rd_data  = (rdValid_q && !rdErr_q) ? sram_q_b : '0;
  end

endmodule

// File: tb/tb_bdd_node_table_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bdd_node_table_ctrl
// Bench for the node-table controller: a behavioural SRAM, a directed opening
// with hand-computed expectations, then randomized traffic compared every
// cycle against a table-level reference model.
// -----------------------------------------------------------------------------
module tb_bdd_node_table_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 34;
  localparam int DEPTH = 8;
  localparam int NR    = 2;
  localparam int IW    = 1;

  logic            clk;
  logic            rst;
  logic            clear;
  logic [NR-1:0]   wr_req;
  logic [NR*DW-1:0] wr_data;
  logic [NR-1:0]   wr_gnt;
  logic [AW-1:0]   wr_addr;
  logic [NR-1:0]   rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]   rd_gnt;
  logic            rd_valid;
  logic [IW-1:0]   rd_id;
  logic [DW-1:0]   rd_data;
  logic            rd_err;
  logic [AW:0]     count;
  logic            full;
  logic [DW-1:0]   sram_data_a;
  logic [AW-1:0]   sram_addr_a;
  logic            sram_we_a;
  logic [AW-1:0]   sram_addr_b;
  logic [DW-1:0]   sram_q_b;

  int tests    = 0;
  int failures = 0;

  bdd_node_table_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NUM_REQ    (NR),
    .ID_WIDTH   (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .wr_addr     (wr_addr),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_valid    (rd_valid),
    .rd_id       (rd_id),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .count       (count),
    .full        (full),
    .sram_data_a (sram_data_a),
    .sram_addr_a (sram_addr_a),
    .sram_we_a   (sram_we_a),
    .sram_addr_b (sram_addr_b),
    .sram_q_b    (sram_q_b)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural dual-port SRAM with a registered read port (read-before-write)
  logic [DW-1:0] sramMem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) sramMem[i] = '0;
    sram_q_b = '0;
  end
  always @(posedge clk) begin
    if (sram_we_a) sramMem[sram_addr_a] <= sram_data_a;
    sram_q_b <= sramMem[sram_addr_b];
  end

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge, then lets them settle
  task automatic applyStimulus(input bit r, input bit c, input logic [NR-1:0] wq,
                               input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                               input logic [NR-1:0] rq, input logic [AW-1:0] ra0,
                               input logic [AW-1:0] ra1);
    @(posedge clk);
    #1;
    rst     = r;
    clear   = c;
    wr_req  = wq;
    wr_data = {wd1, wd0};
    rd_req  = rq;
    rd_addr = {ra1, ra0};
    #1;
  endtask

  // ---------------- reference model (table level) ----------------
  logic [DW-1:0] refMem [0:DEPTH-1];
  int            mCount     = 0;
  int            mWrPtr     = 0;
  int            mRdPtr     = 0;
  bit            mPendValid = 1'b0;
  int            mPendId    = 0;
  bit            mPendErr   = 1'b0;
  logic [DW-1:0] mPendData  = '0;

  // First requesting index found walking forward from ptr, or -1
  function automatic int pickRr(input logic [NR-1:0] req, input int ptr);
    logic [NR-1:0] sh;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (ptr + k) % NR;
      sh  = req >> idx;
      if (sh[0]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] wrSlice(input int k);
    logic [NR*DW-1:0] t;
    t = wr_data >> (k * DW);
    return t[DW-1:0];
  endfunction

  function automatic int rdSlice(input int k);
    logic [NR*AW-1:0] t;
    t = rd_addr >> (k * AW);
    return int'(t[AW-1:0]);
  endfunction

  int            wWin;
  int            rWin;
  int            rAddr;
  logic [NR-1:0] expWrGnt;
  logic [NR-1:0] expRdGnt;

  // Compare on every falling edge, then advance the model to the next rising edge
  always @(negedge clk) begin
    wWin = (!rst && !clear && mCount < DEPTH) ? pickRr(wr_req, mWrPtr) : -1;
    rWin = rst ? -1 : pickRr(rd_req, mRdPtr);
    expWrGnt = '0;
    expRdGnt = '0;
    if (wWin >= 0) expWrGnt = (NR)'(1) << wWin;
    if (rWin >= 0) expRdGnt = (NR)'(1) << rWin;

    checkOutput("m_wr_gnt", wr_gnt, expWrGnt);
    checkOutput("m_sram_we_a", sram_we_a, (wWin >= 0));
    if (wWin >= 0) begin
      checkOutput("m_wr_addr", wr_addr, mCount);
      checkOutput("m_sram_addr_a", sram_addr_a, mCount);
      checkOutput("m_sram_data_a", sram_data_a, wrSlice(wWin));
    end else begin
      checkOutput("m_idle_addr_a", sram_addr_a, 0);
      checkOutput("m_idle_data_a", sram_data_a, 0);
    end
    checkOutput("m_rd_gnt", rd_gnt, expRdGnt);
    checkOutput("m_sram_addr_b", sram_addr_b, (rWin >= 0) ? rdSlice(rWin) : 0);
    checkOutput("m_count", count, mCount);
    checkOutput("m_full", full, (mCount == DEPTH));
    checkOutput("m_rd_valid", rd_valid, mPendValid);
    if (mPendValid) begin
      checkOutput("m_rd_id", rd_id, mPendId);
      checkOutput("m_rd_err", rd_err, mPendErr);
    end
    checkOutput("m_rd_data", rd_data, (mPendValid && !mPendErr) ? mPendData : '0);

    if (rst) begin
      mCount     = 0;
      mWrPtr     = 0;
      mRdPtr     = 0;
      mPendValid = 1'b0;
    end else begin
      mPendValid = (rWin >= 0);
      if (rWin >= 0) begin
        mPendId   = rWin;
        rAddr     = rdSlice(rWin);
        mPendErr  = (rAddr >= mCount);
        mPendData = mPendErr ? '0 : refMem[rAddr];
        mRdPtr    = (rWin + 1) % NR;
      end
      if (wWin >= 0) begin
        refMem[mCount] = wrSlice(wWin);
        mCount         = mCount + 1;
        mWrPtr         = (wWin + 1) % NR;
      end
      if (clear) mCount = 0;
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0]   rnd64a;
  logic [63:0]   rnd64b;
  logic [NR-1:0] twoBits;

  initial begin
    rst     = 1'b1;
    clear   = 1'b0;
    wr_req  = 2'b01;
    wr_data = '0;
    rd_req  = 2'b11;
    rd_addr = '0;
    repeat (2) @(posedge clk);
    #2;
    // Reset state, with requests present while rst is high
    checkOutput("rst_count", count, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rd_id", rd_id, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_rd_err", rd_err, 0);
    checkOutput("rst_wr_gnt", wr_gnt, 0);
    checkOutput("rst_rd_gnt", rd_gnt, 0);
    checkOutput("rst_we", sram_we_a, 0);

    // First allocation
    applyStimulus(0, 0, 2'b01, 34'h155, '0, 2'b00, 8'd0, 8'd0);
    checkOutput("t1_wr_gnt", wr_gnt, 2'b01);
    checkOutput("t1_wr_addr", wr_addr, 0);
    checkOutput("t1_we", sram_we_a, 1);
    checkOutput("t1_data_a", sram_data_a, 34'h155);
    applyStimulus(0, 0, 2'b00, '0, '0, 2'b00, 8'd0, 8'd0);
    checkOutput("t1_count", count, 1);

    // Fresh reset, then both writers contend
    applyStimulus(1, 0, 2'b00, '0, '0, 2'b00, 8'd0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 2'b11, DW'(32'h100 + k), DW'(32'h200 + k), 2'b00, 8'd0, 8'd0);
      checkOutput("t2_wr_gnt", wr_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput("t2_wr_addr", wr_addr, k);
    end
    applyStimulus(0, 0, 2'b00, '0, '0, 2'b00, 8'd0, 8'd0);
    checkOutput("t2_count", count, 4);

    // Fill, block at full, then clear
    for (int k = 4; k < 8; k++) begin
      applyStimulus(0, 0, 2'b11, DW'(32'h100 + k), DW'(32'h200 + k), 2'b00, 8'd0, 8'd0);
    end
    applyStimulus(0, 0, 2'b01, 34'h3C, '0, 2'b00, 8'd0, 8'd0);
    checkOutput("t3_count", count, 8);
    checkOutput("t3_full", full, 1);
    checkOutput("t3_full_gnt", wr_gnt, 0);
    checkOutput("t3_full_we", sram_we_a, 0);
    applyStimulus(0, 1, 2'b01, 34'h3C, '0, 2'b00, 8'd0, 8'd0);
    checkOutput("t3_clear_gnt", wr_gnt, 0);
    applyStimulus(0, 0, 2'b01, 34'h0AB, '0, 2'b00, 8'd0, 8'd0);
    checkOutput("t3_cleared_count", count, 0);
    checkOutput("t3_cleared_full", full, 0);
    checkOutput("t3_after_gnt", wr_gnt, 2'b01);
    checkOutput("t3_after_addr", wr_addr, 0);

    // Write 0xA5 at address 2, then two readers of address 2
    applyStimulus(0, 0, 2'b01, 34'h011, '0, 2'b00, 8'd0, 8'd0);
    checkOutput("t4_addr1", wr_addr, 1);
    applyStimulus(0, 0, 2'b01, 34'h0A5, '0, 2'b00, 8'd0, 8'd0);
    checkOutput("t4_addr2", wr_addr, 2);
    applyStimulus(0, 0, 2'b00, '0, '0, 2'b11, 8'd2, 8'd2);
    checkOutput("t4_rd_gnt0", rd_gnt, 2'b01);
    checkOutput("t4_addr_b", sram_addr_b, 2);
    checkOutput("t4_count", count, 3);
    applyStimulus(0, 0, 2'b00, '0, '0, 2'b10, 8'd2, 8'd2);
    checkOutput("t4_rd_gnt1", rd_gnt, 2'b10);
    checkOutput("t4_valid0", rd_valid, 1);
    checkOutput("t4_id0", rd_id, 0);
    checkOutput("t4_data0", rd_data, 34'h0A5);
    checkOutput("t4_err0", rd_err, 0);
    applyStimulus(0, 0, 2'b00, '0, '0, 2'b00, 8'd0, 8'd0);
    checkOutput("t4_valid1", rd_valid, 1);
    checkOutput("t4_id1", rd_id, 1);
    checkOutput("t4_data1", rd_data, 34'h0A5);
    checkOutput("t4_err1", rd_err, 0);

    // Read beyond the allocated range
    applyStimulus(0, 0, 2'b00, '0, '0, 2'b01, 8'd5, 8'd0);
    checkOutput("t5_rd_gnt", rd_gnt, 2'b01);
    applyStimulus(0, 0, 2'b00, '0, '0, 2'b00, 8'd0, 8'd0);
    checkOutput("t5_valid", rd_valid, 1);
    checkOutput("t5_err", rd_err, 1);
    checkOutput("t5_data", rd_data, 0);

    // Reset right after a read grant
    applyStimulus(0, 0, 2'b00, '0, '0, 2'b01, 8'd1, 8'd0);
    checkOutput("t6_rd_gnt", rd_gnt, 2'b01);
    applyStimulus(1, 0, 2'b00, '0, '0, 2'b00, 8'd0, 8'd0);
    applyStimulus(0, 0, 2'b00, '0, '0, 2'b11, 8'd0, 8'd0);
    checkOutput("t6_valid", rd_valid, 0);
    checkOutput("t6_count", count, 0);
    checkOutput("t6_rd_gnt_after", rd_gnt, 2'b01);

    // Randomized traffic, checked by the reference model each cycle
    for (int n = 0; n < 2000; n++) begin
      rnd64a  = {$urandom(), $urandom()};
      rnd64b  = {$urandom(), $urandom()};
      twoBits = NR'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0),
                    twoBits, rnd64a[DW-1:0], rnd64b[DW-1:0],
                    NR'($urandom_range(0, 3)),
                    AW'($urandom_range(0, DEPTH + 3)), AW'($urandom_range(0, DEPTH + 3)));
    end
    applyStimulus(0, 0, 2'b00, '0, '0, 2'b00, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
